multiway_light_ctrl: RTL and testbench

Parametrised multi-switch ("staircase") light controller: N wall switches each pass through a two-flop synchroniser and a per-channel debouncer. The light is then driven by one of two modes. In parity mode the light follows the XNOR/XOR of the debounced switches. In timer mode any debounced switch change toggles the light, with an optional auto-off timeout. It is the registered, debounced, N-channel successor to the team's combinational 3-switch light circuit and sits between raw switch pads and the lamp driver.

---
 rtl/multiway_light_ctrl.sv | 130 +++++++++++++
 tb/tb_multiway_light_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiway_light_ctrl.sv
// Multi-switch staircase light controller.
// Each raw switch is synchronised and debounced. The lamp then runs in one of two modes:
// parity mode follows the XOR/XNOR of the switches, and timer mode toggles on any change
// and can switch itself off after a timeout.
module multiway_light_ctrl #(
  parameter int N_SW       = 3,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 16,
  parameter bit INVERT     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  input  logic            mode,
  output logic [N_SW-1:0] sw_db,
  output logic            chg_pulse,
  output logic            light,
  output logic            timer_active
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam bit            AUTO_OFF   = (TIMEOUT > 0);

  // Odd parity of the debounced switch vector
  function automatic logic parity_of(input logic [N_SW-1:0] v);
    return ^v;
  endfunction

  logic [N_SW-1:0] sync1;
  logic [N_SW-1:0] sync2;
  logic [N_SW-1:0] accept;
  logic [CW-1:0]   cnt [N_SW];
  logic [TW-1:0]   timer;
  logic            light_next;
  logic [TW-1:0]   timer_next;

  // Flag channels whose new level has held long enough to be accepted on this edge
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_SW; i++) begin
      if ((sync2[i] != sw_db[i]) && (cnt[i] == CNT_LAST)) begin
        accept[i] = 1'b1;
      end else begin
        accept[i] = 1'b0;
      end
    end
  end

  // Two-flop synchroniser and per-channel debounce counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sw_db <= '0;
      for (int i = 0; i < N_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      for (int i = 0; i < N_SW; i++) begin
        if (sync2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          sw_db[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Single-cycle pulse when any channel accepts a new level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_pulse <= 1'b0;
    end else begin
      chg_pulse <= |accept;
    end
  end

  // Next lamp/timer state for the selected mode. In timer mode, light=1 with timer=0 only
  // occurs on the first timer-mode edge after parity mode, so that case arms the auto-off.
  always_comb begin
    light_next = light;
    timer_next = timer;
    if (!mode) begin
      light_next = INVERT ^ parity_of(sw_db);
      timer_next = '0;
    end else if (chg_pulse) begin
      if (!light) begin
        light_next = 1'b1;
        timer_next = TIMER_LOAD;
      end else begin
        light_next = 1'b0;
        timer_next = '0;
      end
    end else if (AUTO_OFF && light) begin
      if (timer == '0) begin
        timer_next = TIMER_LOAD;
      end else if (timer == TW'(1)) begin
        light_next = 1'b0;
        timer_next = '0;
      end else begin
        timer_next = timer - TW'(1);
      end
    end else begin
      light_next = light;
      timer_next = timer;
    end
  end

  // Lamp and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light <= 1'b0;
      timer <= '0;
    end else begin
      light <= light_next;
      timer <= timer_next;
    end
  end

  assign timer_active = |timer;

endmodule

// File: tb/tb_multiway_light_ctrl.sv
// Directed bench for multiway_light_ctrl with the default parameters
// (N_SW=3, DEB_CYCLES=4, TIMEOUT=16, INVERT=1).
module tb_multiway_light_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       mode;
  logic [2:0] sw_db;
  logic       chg_pulse;
  logic       light;
  logic       timer_active;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [2:0] sw;
    logic [2:0] exp_db;
    logic       exp_light;
  } vec_t;

  vec_t vecs [8];

  multiway_light_ctrl #(
    .N_SW(3), .DEB_CYCLES(4), .TIMEOUT(16), .INVERT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode),
    .sw_db(sw_db), .chg_pulse(chg_pulse), .light(light), .timer_active(timer_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int hi;
    int unstable;

    vecs[0] = '{3'b000, 3'b000, 1'b1};
    vecs[1] = '{3'b001, 3'b001, 1'b0};
    vecs[2] = '{3'b010, 3'b010, 1'b0};
    vecs[3] = '{3'b011, 3'b011, 1'b1};
    vecs[4] = '{3'b100, 3'b100, 1'b0};
    vecs[5] = '{3'b101, 3'b101, 1'b1};
    vecs[6] = '{3'b110, 3'b110, 1'b1};
    vecs[7] = '{3'b111, 3'b111, 1'b0};

    // Reset state
    rst_n = 1'b0; sw = 3'b000; mode = 1'b0;
    step(2);
    check("reset_light", {31'd0, light}, 32'd0);
    check("reset_db", {29'd0, sw_db}, 32'd0);
    check("reset_chg", {31'd0, chg_pulse}, 32'd0);
    check("reset_tact", {31'd0, timer_active}, 32'd0);
    rst_n = 1'b1;
    step(1);
    check("first_edge_light", {31'd0, light}, 32'd1);

    // Parity sweep
    for (int i = 0; i < 8; i++) begin
      sw = vecs[i].sw;
      step(8);
      check($sformatf("par_db_%0d", i), {29'd0, sw_db}, {29'd0, vecs[i].exp_db});
      check($sformatf("par_light_%0d", i), {31'd0, light}, {31'd0, vecs[i].exp_light});
    end
    sw = 3'b000;
    step(8);

    // Glitch of 3 cycles is rejected
    sw = 3'b001;
    step(3);
    sw = 3'b000;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      step(1);
      if (chg_pulse) pulses++;
    end
    check("glitch_pulses", pulses, 32'd0);
    check("glitch_db", {29'd0, sw_db}, 32'd0);
    check("glitch_light", {31'd0, light}, 32'd1);

    // Held level is accepted exactly at edge k+5
    sw = 3'b001;
    step(5);
    check("deb_db_k4", {29'd0, sw_db}, 32'd0);
    check("deb_chg_k4", {31'd0, chg_pulse}, 32'd0);
    step(1);
    check("deb_db_k5", {29'd0, sw_db}, 32'd1);
    check("deb_chg_k5", {31'd0, chg_pulse}, 32'd1);
    step(1);
    check("deb_chg_k6", {31'd0, chg_pulse}, 32'd0);
    check("deb_light_k6", {31'd0, light}, 32'd0);

    // Timer mode: toggle on and auto-off after 16 cycles
    mode = 1'b1;
    step(2);
    check("tmr_entry_light0", {31'd0, light}, 32'd0);
    check("tmr_entry_tact0", {31'd0, timer_active}, 32'd0);
    sw = 3'b011;
    step(6);
    check("tmr_chg", {31'd0, chg_pulse}, 32'd1);
    check("tmr_light_pre", {31'd0, light}, 32'd0);
    step(1);
    check("tmr_tact_on", {31'd0, timer_active}, 32'd1);
    hi = 0;
    unstable = 0;
    while (light && hi < 40) begin
      if (!timer_active) unstable++;
      hi++;
      step(1);
    end
    check("tmr_high_cycles", hi, 32'd16);
    check("tmr_tact_during", unstable, 32'd0);
    check("tmr_off_light", {31'd0, light}, 32'd0);
    check("tmr_off_tact", {31'd0, timer_active}, 32'd0);

    // On again, then a second change turns it off early
    sw = 3'b001;
    step(7);
    check("tmr2_on", {31'd0, light}, 32'd1);
    step(5);
    sw = 3'b101;
    step(6);
    check("tmr2_chg", {31'd0, chg_pulse}, 32'd1);
    check("tmr2_still_on", {31'd0, light}, 32'd1);
    step(1);
    check("tmr2_off_light", {31'd0, light}, 32'd0);
    check("tmr2_off_tact", {31'd0, timer_active}, 32'd0);

    // Change arriving on the expiry edge: off, no re-arm
    sw = 3'b001;
    step(7);
    check("exp_on", {31'd0, light}, 32'd1);
    step(9);
    sw = 3'b101;
    step(6);
    check("exp_chg", {31'd0, chg_pulse}, 32'd1);
    check("exp_light_pre", {31'd0, light}, 32'd1);
    check("exp_tact_pre", {31'd0, timer_active}, 32'd1);
    step(1);
    check("exp_light", {31'd0, light}, 32'd0);
    check("exp_tact", {31'd0, timer_active}, 32'd0);
    step(10);
    check("exp_no_rearm", {31'd0, light}, 32'd0);

    // Simultaneous two-channel flip in timer mode: one pulse, one toggle
    sw = 3'b110;
    pulses = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      if (chg_pulse) pulses++;
    end
    check("sim_tmr_pulses", pulses, 32'd1);
    check("sim_tmr_light", {31'd0, light}, 32'd1);

    // Back to parity mode: parity value, timer cleared
    mode = 1'b0;
    step(1);
    check("m10_light", {31'd0, light}, 32'd1);
    check("m10_tact", {31'd0, timer_active}, 32'd0);

    // Simultaneous two-channel flip in parity mode: light unchanged
    sw = 3'b000;
    pulses = 0;
    unstable = 0;
    for (int j = 0; j < 10; j++) begin
      step(1);
      if (chg_pulse) pulses++;
      if (!light) unstable++;
    end
    check("sim_par_pulses", pulses, 32'd1);
    check("sim_par_glitches", unstable, 32'd0);
    check("sim_par_db", {29'd0, sw_db}, 32'd0);
    sw = 3'b011;
    step(8);
    check("par_011_light", {31'd0, light}, 32'd1);

    // Enter timer mode with light on: auto-off armed at entry
    mode = 1'b1;
    step(1);
    check("m01_light", {31'd0, light}, 32'd1);
    check("m01_tact", {31'd0, timer_active}, 32'd1);
    step(7);

    // Async reset mid-countdown
    #2;
    rst_n = 1'b0;
    sw = 3'b111;
    #1;
    check("arst_light", {31'd0, light}, 32'd0);
    check("arst_tact", {31'd0, timer_active}, 32'd0);
    check("arst_db", {29'd0, sw_db}, 32'd0);
    check("arst_chg", {31'd0, chg_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    check("rel_db_k4", {29'd0, sw_db}, 32'd0);
    step(1);
    check("rel_db_k5", {29'd0, sw_db}, 32'd7);
    check("rel_chg_k5", {31'd0, chg_pulse}, 32'd1);
    step(1);
    check("rel_light", {31'd0, light}, 32'd1);
    check("rel_chg_k6", {31'd0, chg_pulse}, 32'd0);
    check("rel_tact", {31'd0, timer_active}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
